// File: rtl/uart_load_ctrl_pkg.sv
// uart_load_ctrl_pkg: opcodes, command field layout and FSM states for the UART load controller
package uart_load_ctrl_pkg;
   localparam logic [7:0] OP_LOAD      = 8'h01;
   localparam logic [7:0] OP_RUN       = 8'h02;
   localparam logic [7:0] OP_STEP      = 8'h03;
   localparam logic [7:0] OP_HALT      = 8'h04;
   localparam logic [7:0] OP_CPU_RESET = 8'h05;
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 24;
   localparam int OPND_W = 24;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
endpackage

// File: rtl/uart_load_ctrl.sv
// uart_load_ctrl: decodes host command words to load instruction memory and drive pipeline run/step/halt/reset
module uart_load_ctrl
   import uart_load_ctrl_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              word_valid,
   input  logic [31:0]       word_in,
   input  logic              cpu_halted,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_en,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam logic [31:0] MAX_N = 32'd1 << ADDR_W;
   state_t              state, state_d;
   logic [ADDR_W:0]     cnt, cnt_d;
   logic [ADDR_W-1:0]   ptr, ptr_d, addr_d;
   logic [31:0]         wdata_d;
   logic                we_d, en_d, crst_d, busy_d, done_d, err_d;
   logic [7:0]          opc;
   logic [OPND_W-1:0]   opnd;
   logic                load_ok, halt_cmd;
   assign opc      = word_in[OPC_HI:OPC_LO];
   assign opnd     = word_in[OPND_W-1:0];
   assign load_ok  = (opnd != '0) && ({8'd0, opnd} <= MAX_N);
   assign halt_cmd = word_valid && (opc == OP_HALT);
   // next-state and next-output decode; busy is held one extra cycle past the leaving edge
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      ptr_d   = ptr;
      addr_d  = imem_addr;
      wdata_d = imem_wdata;
      we_d    = 1'b0;
      en_d    = 1'b0;
      crst_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = err;
      case (state)
         IDLE: if (word_valid) begin
            if (opc == OP_LOAD && load_ok) begin
               state_d = LOAD;
               cnt_d   = opnd[ADDR_W:0];
               ptr_d   = '0;
               addr_d  = '0;
               crst_d  = 1'b1;
               err_d   = 1'b0;
            end else if (opc == OP_RUN) begin
               state_d = RUN;
               en_d    = 1'b1;
               err_d   = 1'b0;
            end else if (opc == OP_STEP) begin
               en_d    = 1'b1;
               done_d  = 1'b1;
               err_d   = 1'b0;
            end else if (opc == OP_CPU_RESET) begin
               crst_d  = 1'b1;
               err_d   = 1'b0;
            end else if (opc == OP_HALT) begin
               err_d   = 1'b0;
            end else begin
               err_d   = 1'b1;
            end
         end
         LOAD: if (word_valid) begin
            we_d    = 1'b1;
            wdata_d = word_in;
            addr_d  = ptr;
            ptr_d   = ptr + 1'b1;
            cnt_d   = cnt - 1'b1;
            if (cnt == (ADDR_W+1)'(1)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         RUN: begin
            en_d = 1'b1;
            if (word_valid && !halt_cmd) err_d = 1'b1;
            if (cpu_halted || halt_cmd) begin
               en_d    = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state != IDLE) || (state_d != IDLE);
   end
   // state, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         ptr        <= '0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         imem_we    <= 1'b0;
         cpu_en     <= 1'b0;
         cpu_rst    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         ptr        <= ptr_d;
         imem_addr  <= addr_d;
         imem_wdata <= wdata_d;
         imem_we    <= we_d;
         cpu_en     <= en_d;
         cpu_rst    <= crst_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
      end
   end
endmodule

// File: doc/uart_load_ctrl.md
Name: uart_load_ctrl

Overview:
- Command sequencer behind the UART 4-byte word assembler.
- Consumes assembled 32-bit words, each qualified by a one-cycle valid pulse.
- Decodes each word as a command, or as payload when a load is in progress.
- Loads the pipeline's instruction memory and drives the pipeline's run, step, halt and reset controls, so the host PC can program and run the processor over serial.

Parameters:
ADDR_W, 10, instruction memory word-address width; maximum load length is 2^ADDR_W words.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
word_valid  input  1  one-cycle pulse: word_in holds a new assembled word
word_in  input  32  assembled word; command format [31:24] opcode, [23:0] operand
cpu_halted  input  1  pipeline reached a halt instruction (level)
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_W  instruction memory word address
imem_wdata  output  32  instruction memory write data
cpu_en  output  1  pipeline clock enable
cpu_rst  output  1  one-cycle synchronous reset pulse to the pipeline
busy  output  1  high while in LOAD or RUN
done  output  1  one-cycle pulse at load complete or run end
err  output  1  sticky error flag

Behaviour:
- Reset: state IDLE; all outputs 0; address and word counters 0. Reset mid-load aborts the load; already-written words stay in memory.
- Opcodes: 0x01 LOAD (operand = N words), 0x02 RUN, 0x03 STEP, 0x04 HALT, 0x05 CPU_RESET. Any other opcode is illegal.
- All outputs are registered. Response appears the cycle after word_valid.
- IDLE state:
  - LOAD with 1 <= N <= 2^ADDR_W: counter set to N, imem_addr set to 0, cpu_rst pulses once, next state LOAD, err cleared.
  - LOAD with N = 0 or N > 2^ADDR_W: err set, state stays IDLE.
  - RUN: cpu_en set to 1, next state RUN, err cleared.
  - STEP: cpu_en high for exactly one cycle, state stays IDLE, done pulses in the same cycle.
  - CPU_RESET: cpu_rst pulses once.
  - HALT: no-op.
  - Illegal opcode: err set.
- LOAD state:
  - Every word_valid is payload, never decoded.
  - Next cycle: imem_we=1, imem_wdata=word_in, imem_addr=current address. Address then increments and counter decrements.
  - cpu_en is held at 0 throughout LOAD.
  - After the write of word N: state goes to IDLE, done pulses in the same cycle as the last imem_we, busy drops the following cycle.
  - Back-to-back word_valid on consecutive cycles is accepted.
  - Address wrap cannot occur because N is capped at load start.
- RUN state:
  - cpu_halted=1 goes to IDLE: cpu_en=0, done pulse.
  - word_valid with HALT goes to IDLE: cpu_en=0, done pulse.
  - HALT and cpu_halted in the same cycle produce exactly one done pulse.
  - Any other word in RUN sets err and is otherwise ignored.
  - cpu_halted in IDLE or LOAD is ignored.
- err is cleared only by a subsequently accepted command in IDLE, or by reset.
- imem_we is never high outside LOAD. cpu_en and imem_we are never high together.

Decomposition:
- Shared package: opcode constants (OP_LOAD, OP_RUN, OP_STEP, OP_HALT, OP_CPU_RESET), state encoding (IDLE, LOAD, RUN), command field positions.
- No sub-module is needed. Decoding and counters are small enough to sit in one FSM.

Test Plan:
1. LOAD N=3 (0x01000003), then words 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 -> cpu_rst pulses once; imem_we writes addr 0,1,2 with those data; done pulses with the third write; busy=0 after.
2. LOAD N=0 (0x01000000), then opcode 0x7F -> err=1 and state IDLE in both cases; a following CPU_RESET clears err.
3. RUN (0x02000000) then cpu_halted=1 after 20 cycles -> cpu_en high for exactly those cycles, then 0; one done pulse.
4. RUN, then HALT (0x04000000) arriving in the same cycle as cpu_halted -> IDLE, a single done pulse; an extra LOAD word sent during RUN sets err and is not written.
5. STEP sent twice -> cpu_en high for exactly 1 cycle each time; imem_we stays 0.
6. LOAD N=4, reset asserted after 2 words -> all outputs 0 immediately; a new LOAD N=1 restarts writing at addr 0.
